// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin scheduler sharing one uart_send transmitter
// between N_REQ byte producers. One byte per grant; the frame interval
// is enforced by counting because uart_send exposes no busy flag.

// Per-requester slice: "above pointer" request and the masked id/byte
// this lane contributes when it holds the grant.
module uart_tx_arb_lane #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic [IDW-1:0] last_i,
  input  logic           req_i,
  input  logic           gnt_i,
  input  logic [7:0]     byte_i,
  output logic           req_hi_o,
  output logic [IDW-1:0] id_o,
  output logic [7:0]     byte_o
);
  assign req_hi_o = req_i && (IDW'(IDX) > last_i);
  assign id_o     = gnt_i ? IDW'(IDX) : '0;
  assign byte_o   = gnt_i ? byte_i : 8'h00;
endmodule

module uart_tx_arb #(
  parameter  int CLK_FREQ     = 50_000_000,
  parameter  int UART_BPS     = 115200,
  parameter  int FRAME_BITS   = 10,
  parameter  int GUARD        = 4,
  parameter  int N_REQ        = 4,
  localparam int BPS_CNT      = CLK_FREQ / UART_BPS,
  localparam int FRAME_CYCLES = BPS_CNT * FRAME_BITS + GUARD,
  localparam int IDW          = $clog2(N_REQ),
  localparam int CW           = $clog2(FRAME_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  if (FRAME_CYCLES < 2) begin : g_chk_frame
    $error("uart_tx_arb: FRAME_CYCLES must be >= 2");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
    $error("uart_tx_arb: N_REQ must be in 2..8");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               busy_q, busy_d;

  // Arbitration: requests strictly above the pointer win first; otherwise
  // wrap to the lowest request. Lowest set bit isolated by two's complement.
  logic [N_REQ-1:0]            req_hi, pick, gnt;
  logic [N_REQ-1:0][IDW-1:0]   lane_id;
  logic [N_REQ-1:0][7:0]       lane_byte;
  logic [IDW-1:0][N_REQ-1:0]   id_t;
  logic [7:0][N_REQ-1:0]       byte_t;
  logic [IDW-1:0]              win_id;
  logic [7:0]                  win_data;

  assign pick = (|req_hi) ? req_hi : req;
  assign gnt  = pick & (~pick + N_REQ'(1));

  for (genvar j = 0; j < N_REQ; j++) begin : g_lane
    uart_tx_arb_lane #(.IDW(IDW), .IDX(j)) u_lane (
      .last_i   (last_q),
      .req_i    (req[j]),
      .gnt_i    (gnt[j]),
      .byte_i   (req_data[8*j +: 8]),
      .req_hi_o (req_hi[j]),
      .id_o     (lane_id[j]),
      .byte_o   (lane_byte[j])
    );
    for (genvar b = 0; b < IDW; b++) begin : g_id_t
      assign id_t[b][j] = lane_id[j][b];
    end
    for (genvar b = 0; b < 8; b++) begin : g_byte_t
      assign byte_t[b][j] = lane_byte[j][b];
    end
  end

  // Only the granted lane drives non-zero values, so OR-reduction is a mux.
  for (genvar b = 0; b < IDW; b++) begin : g_win_id
    assign win_id[b] = |id_t[b];
  end
  for (genvar b = 0; b < 8; b++) begin : g_win_data
    assign win_data[b] = |byte_t[b];
  end

  // Next state: grant from IDLE loads every output register at once;
  // WAIT counts down the frame interval and ignores requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = '0;
    en_d    = 1'b0;
    data_d  = data_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          ack_d   = gnt;
          en_d    = 1'b1;
          data_d  = win_data;
          gid_d   = win_id;
          last_d  = win_id;
          busy_d  = 1'b1;
          cnt_d   = CW'(FRAME_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; pointer resets so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IDW'(N_REQ - 1);
      ack_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

  assign ack          = ack_q;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign grant_id     = gid_q;
  assign busy         = busy_q;

  a_ack_en: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ack_q) && ((|ack_q) == en_q));

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: FRAME_CYCLES = 10*10+2 = 102.
module tb_uart_tx_arb;
  localparam int FC = 102;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arb #(.CLK_FREQ(1000), .UART_BPS(100), .FRAME_BITS(10), .GUARD(2), .N_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .grant_id(grant_id), .busy(busy)
  );

  int nvec = 0;
  int nmiss = 0;

  // Grant log and ack/tx_en coincidence monitor, sampled after outputs settle.
  int         cyc = 0;
  int         n_bad = 0;
  int         q_cyc[$];
  logic [7:0] q_dat[$];
  logic [1:0] q_gid[$];
  logic [3:0] q_ack[$];
  always @(posedge clk) begin
    #2;
    cyc++;
    if (((|ack) !== uart_tx_en) || !$onehot0(ack)) n_bad++;
    if (uart_tx_en === 1'b1) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(uart_tx_data);
      q_gid.push_back(grant_id);
      q_ack.push_back(ack);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_en(input int maxc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (uart_tx_en === 1'b1) ok = 1'b1;
    end
    nvec++;
    if (!ok) begin
      nmiss++;
      $display("FAIL %s: got no uart_tx_en expected one within %0d cycles", nm, maxc);
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    nvec++;
    if (!ok) begin
      nmiss++;
      $display("FAIL %s: got busy=1 expected 0 within %0d cycles", nm, maxc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Check that log entries [base, base+n) match the expected grant sequence.
  task automatic chk_log(input string nm, input int base, input int n,
                         input logic [7:0] dat [8], input logic [1:0] gid [8]);
    chk($sformatf("%s grants", nm), q_cyc.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < q_cyc.size()) begin
        chk($sformatf("%s data%0d", nm, i), q_dat[base+i], dat[i]);
        chk($sformatf("%s gid%0d", nm, i), q_gid[base+i], gid[i]);
        chk($sformatf("%s ack%0d", nm, i), q_ack[base+i], 4'b0001 << gid[i]);
        if (i > 0) chk($sformatf("%s gap%0d", nm, i), q_cyc[base+i] - q_cyc[base+i-1], FC + 1);
      end
    end
  endtask

  typedef struct {
    int          ncyc;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        en;
    logic [7:0]  tdata;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t       tbl[14];
  int         base;
  logic [7:0] edat [8];
  logic [1:0] egid [8];

  initial begin
    //          ncyc rst req    data           ack    en   tdata  gid  busy
    tbl[0]  = '{3,   0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1,   1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{1,   1, 4'h4, 32'h00A5_0000, 4'h4, 1'b1, 8'hA5, 2'd2, 1'b1};
    tbl[3]  = '{1,   1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'hA5, 2'd2, 1'b1};
    tbl[4]  = '{100, 1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'hA5, 2'd2, 1'b1};
    tbl[5]  = '{1,   1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'hA5, 2'd2, 1'b0};
    tbl[6]  = '{1,   1, 4'h1, 32'h0000_0077, 4'h1, 1'b1, 8'h77, 2'd0, 1'b1};
    tbl[7]  = '{1,   1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h77, 2'd0, 1'b1};
    tbl[8]  = '{100, 1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h77, 2'd0, 1'b1};
    tbl[9]  = '{1,   1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h77, 2'd0, 1'b0};
    tbl[10] = '{1,   1, 4'hA, 32'hC300_3C00, 4'h2, 1'b1, 8'h3C, 2'd1, 1'b1};
    tbl[11] = '{1,   0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[12] = '{1,   1, 4'hA, 32'hC300_3C00, 4'h2, 1'b1, 8'h3C, 2'd1, 1'b1};
    tbl[13] = '{2,   0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};

    foreach (tbl[i]) begin
      rst_n    = tbl[i].rst_n;
      req      = tbl[i].req;
      req_data = tbl[i].data;
      repeat (tbl[i].ncyc) @(negedge clk);
      chk($sformatf("vec%0d ack", i),   ack,          tbl[i].ack);
      chk($sformatf("vec%0d en", i),    uart_tx_en,   tbl[i].en);
      chk($sformatf("vec%0d data", i),  uart_tx_data, tbl[i].tdata);
      chk($sformatf("vec%0d gid", i),   grant_id,     tbl[i].gid);
      chk($sformatf("vec%0d busy", i),  busy,         tbl[i].busy);
    end

    // Simultaneous requests from reset release, each dropped after its ack.
    req = 4'hF;
    req_data = 32'h4433_2211;
    @(negedge clk);
    base = q_cyc.size();
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_en(300, $sformatf("simul grant%0d", g));
      req = req & ~ack;
    end
    repeat (250) @(negedge clk);
    edat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
    egid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    chk_log("simul", base, 4, edat, egid);

    // Fairness: requesters 0 and 3 held permanently.
    rst_n = 1'b0;
    req = 4'b1001;
    req_data = 32'hB300_00B0;
    repeat (2) @(negedge clk);
    base = q_cyc.size();
    rst_n = 1'b1;
    for (int g = 0; g < 6; g++) wait_en(300, $sformatf("fair grant%0d", g));
    req = 4'h0;
    edat = '{8'hB0, 8'hB3, 8'hB0, 8'hB3, 8'hB0, 8'hB3, 8'h0, 8'h0};
    egid = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
    chk_log("fair", base, 6, edat, egid);

    // Withdrawal: req[1] pulsed during WAIT must never be granted.
    req = 4'h0;
    do_reset();
    base = q_cyc.size();
    req = 4'b0001;
    req_data = 32'h0000_005C;
    wait_en(10, "withdraw grant");
    req = 4'h0;
    repeat (20) @(negedge clk);
    req = 4'b0010;
    req_data = 32'h0000_EE00;
    repeat (5) @(negedge clk);
    req = 4'h0;
    chk("withdraw busy mid", busy, 1'b1);
    wait_idle(200, "withdraw idle");
    repeat (150) @(negedge clk);
    edat = '{8'h5C, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    egid = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    chk_log("withdraw", base, 1, edat, egid);

    // Data-change immunity after the arbitration cycle.
    do_reset();
    req = 4'b0100;
    req_data = 32'h005A_0000;
    wait_en(10, "immune grant");
    req_data = 32'h00FF_0000;
    req = 4'h0;
    chk("immune T+1", uart_tx_data, 8'h5A);
    repeat (60) @(negedge clk);
    chk("immune mid", uart_tx_data, 8'h5A);
    wait_idle(200, "immune idle");
    repeat (10) @(negedge clk);
    chk("immune idle data", uart_tx_data, 8'h5A);
    req = 4'b0100;
    wait_en(10, "immune regrant");
    req = 4'h0;
    chk("immune new data", uart_tx_data, 8'hFF);
    chk("immune new gid", grant_id, 2'd2);
    wait_idle(200, "immune idle2");

    // Reset in the middle of WAIT at counter == 50.
    do_reset();
    req = 4'b0010;
    req_data = 32'h0000_1200;
    wait_en(10, "rst grant");
    req = 4'h0;
    repeat (51) @(negedge clk);
    chk("rst busy before", busy, 1'b1);
    rst_n = 1'b0;
    req = 4'b1001;
    req_data = 32'hD300_00D0;
    @(negedge clk);
    chk("rst ack", ack, 4'h0);
    chk("rst en", uart_tx_en, 1'b0);
    chk("rst data", uart_tx_data, 8'h00);
    chk("rst gid", grant_id, 2'd0);
    chk("rst busy", busy, 1'b0);
    @(negedge clk);
    base = q_cyc.size();
    rst_n = 1'b1;
    wait_en(10, "post-rst grant0");
    wait_en(300, "post-rst grant1");
    req = 4'h0;
    edat = '{8'hD0, 8'hD3, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    egid = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    chk_log("post-rst", base, 2, edat, egid);
    repeat (5) @(negedge clk);

    chk("ack/en coincidence errors", n_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
